// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset PC and phase encoding for the CPU core
package cpu_pkg;
  localparam int PC_W = 16;
  localparam int IR_W = 16;
  localparam int D_W = 8;
  localparam int REG_AW = 3;
  localparam int NREG = 1 << REG_AW;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
  typedef enum logic [2:0] {HALT, P0, P1, P2, P3} phase_t;
endpackage

// File: rtl/reg_file_8x8.sv
// reg_file_8x8: 8x8 register file, two async read ports, one sync write port
module reg_file_8x8
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [D_W-1:0]    wdata,
  input  logic [REG_AW-1:0] ra_sel,
  output logic [D_W-1:0]    ra,
  input  logic [REG_AW-1:0] rb_sel,
  output logic [D_W-1:0]    rb
);
  logic [D_W-1:0] mem [NREG];
  // clear every register on reset, otherwise commit the enabled write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign ra = mem[ra_sel];
  assign rb = mem[rb_sel];
endmodule

// File: rtl/cpu_state_regs.sv
// cpu_state_regs: phase sequencer, PC/IR fetch state and register file of the 8-bit CPU
module cpu_state_regs
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              RUN,
  output logic              CS0,
  output logic              CS1,
  output logic              CS2,
  output logic              CS3,
  output logic [PC_W-1:0]   IADDR,
  output logic              IRD,
  input  logic [IR_W-1:0]   IDATA,
  output logic [PC_W-1:0]   PC,
  output logic [IR_W-1:0]   IR,
  input  logic              PCupdate,
  input  logic [PC_W-1:0]   PCnew,
  input  logic              Rupdate,
  input  logic [REG_AW-1:0] Raddr,
  input  logic [D_W-1:0]    Rdata,
  input  logic [REG_AW-1:0] RA_sel,
  output logic [D_W-1:0]    RA,
  input  logic [REG_AW-1:0] RB_sel,
  output logic [D_W-1:0]    RB,
  output logic              HALTED
);
  phase_t state, nxt;
  logic [3:0] cs;
  logic [PC_W-1:0] pc;
  logic [IR_W-1:0] ir;
  // RUN only matters in HALT and P3, so an instruction always completes
  always_comb
    nxt = state == HALT ? (RUN ? P0 : HALT) :
          state == P0   ? P1 :
          state == P1   ? P2 :
          state == P2   ? P3 :
          (RUN ? P0 : HALT);
  // phase register with strobes and halt flag registered from the next phase
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      state  <= HALT;
      cs     <= '0;
      HALTED <= 1'b1;
    end else begin
      state  <= nxt;
      cs     <= {nxt == P3, nxt == P2, nxt == P1, nxt == P0};
      HALTED <= nxt == HALT;
    end
  // fetch at the end of P0; a write-back jump at the end of P3 replaces the increment
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == P0) begin
      pc <= pc + 16'd1;
      ir <= IDATA;
    end else if (state == P3 && PCupdate) pc <= PCnew;
  reg_file_8x8 u_rf (
    .clk(CLK), .rst_n(RST_n), .we(state == P3 && Rupdate),
    .waddr(Raddr), .wdata(Rdata),
    .ra_sel(RA_sel), .ra(RA), .rb_sel(RB_sel), .rb(RB)
  );
  assign {CS3, CS2, CS1, CS0} = cs;
  assign IRD   = cs[0];
  assign IADDR = pc;
  assign PC    = pc;
  assign IR    = ir;
endmodule

// File: tb/tb_cpu_state_regs.sv
// tb_cpu_state_regs: randomized bench against an instruction-level reference model
module tb_cpu_state_regs;
  logic CLK = 0, RST_n = 0, RUN = 0;
  logic CS0, CS1, CS2, CS3, IRD, HALTED;
  logic [15:0] IADDR, IDATA = 0, PC, IR, PCnew = 0;
  logic PCupdate = 0, Rupdate = 0;
  logic [2:0] Raddr = 0, RA_sel = 0, RB_sel = 0;
  logic [7:0] Rdata = 0, RA, RB;
  logic [3:0] cs;
  int checks = 0, errors = 0;
  int m_ph;
  logic [15:0] m_pc, m_ir;
  logic [7:0] m_regs [8];

  cpu_state_regs dut (
    .CLK(CLK), .RST_n(RST_n), .RUN(RUN), .CS0(CS0), .CS1(CS1), .CS2(CS2), .CS3(CS3),
    .IADDR(IADDR), .IRD(IRD), .IDATA(IDATA), .PC(PC), .IR(IR),
    .PCupdate(PCupdate), .PCnew(PCnew), .Rupdate(Rupdate), .Raddr(Raddr), .Rdata(Rdata),
    .RA_sel(RA_sel), .RA(RA), .RB_sel(RB_sel), .RB(RB), .HALTED(HALTED)
  );
  assign cs = {CS3, CS2, CS1, CS0};
  always #5 CLK = ~CLK;

  function automatic logic [3:0] exp_cs();
    return m_ph == 4 ? 4'b0000 : 4'(1 << m_ph);
  endfunction

  task automatic model_reset();
    m_ph = 4; m_pc = 16'h0000; m_ir = 16'h0000;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
  endtask

  // one clock: the model applies the instruction-level rules with the inputs seen at the edge
  task automatic cyc();
    @(posedge CLK);
    if (m_ph == 4) m_ph = RUN ? 0 : 4;
    else if (m_ph == 0) begin m_ir = IDATA; m_pc = m_pc + 16'd1; m_ph = 1; end
    else if (m_ph < 3) m_ph = m_ph + 1;
    else begin
      if (PCupdate) m_pc = PCnew;
      if (Rupdate) m_regs[Raddr] = Rdata;
      m_ph = RUN ? 0 : 4;
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    PCupdate = 0; Rupdate = 0;
  endtask

  task automatic go_to(input int p);
    idle_inputs();
    for (int i = 0; i < 10 && m_ph != p; i++) cyc();
    checks++;
    if (m_ph != p) begin errors++; $display("FAIL go_to phase %0d not reached, at %0d", p, m_ph); end
  endtask

  task automatic test_reset();
    RST_n = 0; model_reset();
    #12;
    checks++; if (cs !== 4'b0000 || HALTED !== 1'b1 || IRD !== 1'b0) begin errors++; $display("FAIL reset_strobes cs=%b halted=%b ird=%b want 0000 1 0", cs, HALTED, IRD); end
    checks++; if (PC !== 16'h0000 || IR !== 16'h0000 || IADDR !== 16'h0000) begin errors++; $display("FAIL reset_pc_ir pc=%h ir=%h iaddr=%h want 0", PC, IR, IADDR); end
    checks++; if (RA !== 8'h00 || RB !== 8'h00) begin errors++; $display("FAIL reset_regs ra=%h rb=%h want 00", RA, RB); end
    @(negedge CLK); RST_n = 1;
  endtask

  task automatic test_cycling();
    RUN = 1; IDATA = 16'h1234; idle_inputs();
    for (int i = 0; i < 13; i++) begin
      cyc();
      checks++; if (cs !== exp_cs() || IRD !== (m_ph == 0) || IADDR !== m_pc) begin errors++; $display("FAIL cycling cyc%0d cs=%b iaddr=%h want %b %h", i, cs, IADDR, exp_cs(), m_pc); end
    end
    checks++; if (PC !== 16'd3 || IR !== 16'h1234 || !CS0) begin errors++; $display("FAIL cycling_end pc=%h ir=%h cs=%b want 0003 1234 0001", PC, IR, cs); end
  endtask

  task automatic test_reg_write();
    go_to(3);
    Rupdate = 1; Raddr = 5; Rdata = 8'hA7; RA_sel = 5; #1;
    checks++; if (RA !== 8'h00) begin errors++; $display("FAIL rw_p3_old ra=%h want 00", RA); end
    cyc(); idle_inputs(); #1;
    checks++; if (RA !== 8'hA7) begin errors++; $display("FAIL rw_after ra=%h want a7", RA); end
    go_to(1);
    Rupdate = 1; Raddr = 6; Rdata = 8'h55; RB_sel = 6;
    cyc(); idle_inputs(); go_to(0); #1;
    checks++; if (RB !== 8'h00) begin errors++; $display("FAIL rw_p1_ignored rb=%h want 00", RB); end
  endtask

  task automatic test_branch();
    go_to(3); PCupdate = 1; PCnew = 16'h000F; cyc(); idle_inputs();
    go_to(3);
    checks++; if (PC !== 16'h0010) begin errors++; $display("FAIL br_setup pc=%h want 0010", PC); end
    PCupdate = 1; PCnew = 16'h0200; Rupdate = 1; Raddr = 2; Rdata = 8'h3C;
    cyc(); idle_inputs();
    checks++; if (IADDR !== 16'h0200 || cs !== 4'b0001) begin errors++; $display("FAIL br_target iaddr=%h cs=%b want 0200 0001", IADDR, cs); end
    cyc(); RA_sel = 2; #1;
    checks++; if (PC !== 16'h0201 || RA !== 8'h3C) begin errors++; $display("FAIL br_after pc=%h r2=%h want 0201 3c", PC, RA); end
  endtask

  task automatic test_wrap();
    go_to(3); PCupdate = 1; PCnew = 16'hFFFF; cyc(); idle_inputs();
    checks++; if (PC !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup pc=%h want ffff", PC); end
    cyc();
    checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL wrap pc=%h want 0000", PC); end
  endtask

  task automatic test_halt();
    logic [15:0] pc_h, ir_h;
    go_to(1); RUN = 0; cyc(); cyc(); cyc();
    checks++; if (HALTED !== 1'b1 || cs !== 4'b0000 || IRD !== 1'b0) begin errors++; $display("FAIL halt_enter halted=%b cs=%b ird=%b want 1 0000 0", HALTED, cs, IRD); end
    pc_h = m_pc; ir_h = m_ir;
    for (int i = 0; i < 3; i++) begin
      IDATA = 16'($urandom); PCupdate = 1; PCnew = 16'h7777; Rupdate = 1; Raddr = 1; Rdata = 8'hEE;
      cyc();
    end
    idle_inputs(); RA_sel = 1; #1;
    checks++; if (PC !== pc_h || IR !== ir_h || IADDR !== pc_h || RA !== 8'h00 || HALTED !== 1'b1) begin errors++; $display("FAIL halt_hold pc=%h ir=%h r1=%h want %h %h 00", PC, IR, RA, pc_h, ir_h); end
    RUN = 1; cyc();
    checks++; if (cs !== 4'b0001 || HALTED !== 1'b0 || IADDR !== pc_h) begin errors++; $display("FAIL halt_resume cs=%b halted=%b iaddr=%h want 0001 0 %h", cs, HALTED, IADDR, pc_h); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RUN = $urandom_range(0, 5) != 0; IDATA = 16'($urandom);
      PCupdate = 1'($urandom); PCnew = 16'($urandom);
      Rupdate = $urandom_range(0, 3) != 0; Raddr = 3'($urandom); Rdata = 8'($urandom);
      RA_sel = 3'($urandom); RB_sel = (i % 7 == 0) ? RA_sel : 3'($urandom);
      #1;
      checks++; if (RA !== m_regs[RA_sel] || RB !== m_regs[RB_sel]) begin errors++; $display("FAIL rnd_read i=%0d ra=%h rb=%h want %h %h", i, RA, RB, m_regs[RA_sel], m_regs[RB_sel]); end
      cyc();
      checks++; if (cs !== exp_cs() || HALTED !== (m_ph == 4) || IRD !== (m_ph == 0)) begin errors++; $display("FAIL rnd_phase i=%0d cs=%b halted=%b want %b %b", i, cs, HALTED, exp_cs(), m_ph == 4); end
      checks++; if (PC !== m_pc || IADDR !== m_pc || IR !== m_ir) begin errors++; $display("FAIL rnd_state i=%0d pc=%h ir=%h want %h %h", i, PC, IR, m_pc, m_ir); end
    end
  endtask

  task automatic test_async_reset();
    RUN = 1; go_to(3);
    Rupdate = 1; Raddr = 4; Rdata = 8'h99; cyc(); idle_inputs();
    go_to(2); RA_sel = 4; RB_sel = 4; #1;
    checks++; if (RA !== 8'h99) begin errors++; $display("FAIL arst_pre r4=%h want 99", RA); end
    Rupdate = 1; Raddr = 3; Rdata = 8'h11;
    #1 RST_n = 0; model_reset(); #1;
    checks++; if (PC !== 16'h0000 || IR !== 16'h0000 || RA !== 8'h00 || RB !== 8'h00) begin errors++; $display("FAIL arst_state pc=%h ir=%h ra=%h rb=%h want 0", PC, IR, RA, RB); end
    checks++; if (HALTED !== 1'b1 || cs !== 4'b0000 || IRD !== 1'b0) begin errors++; $display("FAIL arst_phase halted=%b cs=%b want 1 0000", HALTED, cs); end
    @(negedge CLK); @(negedge CLK); RST_n = 1; idle_inputs(); RUN = 0;
    cyc(); RA_sel = 3; #1;
    checks++; if (HALTED !== 1'b1 || RA !== 8'h00 || PC !== 16'h0000) begin errors++; $display("FAIL arst_after halted=%b r3=%h pc=%h want 1 00 0000", HALTED, RA, PC); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cycling();
    test_reg_write();
    test_branch();
    test_wrap();
    test_halt();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_state_regs.md
Name: cpu_state_regs

Overview:
- Sequencing and architectural-state block of the 8-bit CPU.
- Generates the four one-hot phase strobes CS0..CS3 that drive every stage.
- Fetches the 16-bit IR from instruction memory and holds the 16-bit PC.
- Holds the 8x8 general register file and consumes the write-back stage's PCupdate/PCnew/Rupdate/Raddr/Rdata outputs, committing them at the end of CS3.

Parameters:
- PC_W, 16, program counter / instruction address width
- IR_W, 16, instruction width
- D_W, 8, register/data width
- NREG, 8, number of general registers (address width 3)
- RESET_PC, 16'h0000, PC value after reset

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_n  in  1  asynchronous active-low reset
- RUN  in  1  level; 1 = sequencer cycles, 0 = halt request
- CS0  out  1  fetch phase strobe
- CS1  out  1  decode/operand-read phase strobe
- CS2  out  1  execute phase strobe
- CS3  out  1  write-back phase strobe
- IADDR  out  16  instruction memory address (= PC)
- IRD  out  1  instruction read strobe (= CS0)
- IDATA  in  16  instruction memory read data, sampled at end of CS0
- PC  out  16  current program counter
- IR  out  16  current instruction register
- PCupdate  in  1  from write-back: load PC with PCnew at end of CS3
- PCnew  in  16  branch/jump target
- Rupdate  in  1  from write-back: write Rdata into register Raddr at end of CS3
- Raddr  in  3  register write address
- Rdata  in  8  register write data
- RA_sel  in  3  read port A address
- RA  out  8  read port A data (combinational)
- RB_sel  in  3  read port B address
- RB  out  8  read port B data (combinational)
- HALTED  out  1  1 while sequencer is stopped

Behaviour:
- Reset (RST_n=0, async):
  - PC=RESET_PC, IR=0, all registers=0.
  - Phase state = HALT: CS0..CS3=0, HALTED=1, IRD=0.
- Phase FSM states: HALT, P0, P1, P2, P3. CSn=1 only in Pn, so exactly one strobe is high when not halted.
- Transitions:
  - HALT -> P0 when RUN=1.
  - P0 -> P1 -> P2 -> P3 unconditionally, one cycle each.
  - P3 -> P0 if RUN=1, else P3 -> HALT.
  - RUN is sampled only in P3 and HALT. Deasserting RUN mid-instruction always completes the instruction; the CPU never stops between phases.
- Fetch (P0): IADDR=PC, IRD=1. At the rising edge ending P0: IR<=IDATA, PC<=PC+1 (16-bit wrap, FFFF->0000). IR holds through P1..P3.
- Write-back (P3), committed at the edge ending P3:
  - If PCupdate=1: PC<=PCnew. This overrides the P0 increment already applied; no further increment.
  - If Rupdate=1: reg[Raddr]<=Rdata.
  - Both may occur in the same cycle, independently.
  - PCupdate/Rupdate/Raddr/Rdata/PCnew are ignored in every phase other than P3 and in HALT.
- Register reads: RA/RB are combinational from the array, with no bypass. During P3 they show the pre-write value; a write is visible from the next cycle.
  - RA_sel=RB_sel is legal; both ports return the same value.
  - All 8 registers are writable; R0 is not hardwired to zero.
- IADDR always equals PC, including in HALT. IRD is low in HALT.
- In HALT, PC, IR and registers hold their values.
- Reset asserted mid-instruction: immediate return to the reset state. Any pending write-back is lost.
- Latency: instruction period = 4 cycles. Branch target is fetched in the P0 immediately after the P3 that loaded it.

Decomposition:
- Shared package cpu_pkg:
  - Phase state encoding (HALT, P0..P3).
  - Width constants PC_W, IR_W, D_W, REG_AW=3.
  - RESET_PC.
- Sub-module reg_file_8x8:
  - 2 async read ports, 1 synchronous write port with enable, async active-low clear.
  - Instantiated once.
- Phase FSM, PC and IR stay in the top module.

Test Plan:
- Reset, RUN=1, IDATA=16'h1234 constant -> CS0..CS3 one-hot cycling with period 4. After 3 instructions PC=3, IR=16'h1234, IADDR sequence 0,1,2.
- Rupdate=1, Raddr=5, Rdata=8'hA7 in P3, RA_sel=5 -> RA=8'h00 during P3, RA=8'hA7 from the next cycle. Rupdate pulsed in P1 -> no write.
- PC=16'h0010 in P3 with PCupdate=1, PCnew=16'h0200, and simultaneously Rupdate=1, Raddr=2, Rdata=8'h3C -> next P0 IADDR=16'h0200, then PC=16'h0201 after fetch, reg2=8'h3C.
- PC=16'hFFFF at P0 -> PC=16'h0000 after fetch.
- RUN dropped during P1 -> P2, P3 complete, then HALTED=1 with CS all 0 and PC/IR held. RUN=1 again -> resumes at P0 on the next cycle.
- RST_n pulsed low mid-P2 after registers were written -> outputs go immediately to reset values: PC=0, IR=0, RA=RB=0, HALTED=1.
